instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word reads to instruction memory and buffers
// the returned words with their addresses in a 2-entry prefetch queue.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD     = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_read_req,
  input  logic        mem_read_ack,
  input  logic [31:0] mem_read_data,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  localparam logic [31:0] RESET_PC = {RESET_VECTOR[31:2], 2'b00};

  logic [1:0]  state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        req_q, req_d;
  logic [31:0] word_q [2];
  logic [31:0] word_d [2];
  logic [31:0] pc_q   [2];
  logic [31:0] pc_d   [2];

  logic        pop;
  logic        ack;
  logic [1:0]  count_pop;
  logic [31:0] target_aligned;
  logic [31:0] fetch_pc_inc;

  assign pop            = (count_q != 2'd0) && instr_ready;
  assign ack            = mem_read_ack && (state_q != S_IDLE);
  assign count_pop      = count_q - {1'b0, pop};
  assign target_aligned = branch_target & 32'hFFFF_FFFC;
  assign fetch_pc_inc   = fetch_pc_q + 32'd4;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    word_d     = word_q;
    pc_d       = pc_q;

    if (branch_taken) begin
      // A redirect wins over pop and push: the queue simply empties.
      count_d    = 2'd0;
      fetch_pc_d = target_aligned;
      if ((state_q != S_IDLE) && !ack) begin
        // The old request cannot be withdrawn; its data is dropped on arrival.
        state_d = S_DISCARD;
      end else begin
        state_d    = S_REQ;
        mem_addr_d = target_aligned;
      end
    end else begin
      if (pop) begin
        word_d[0] = word_q[1];
        pc_d[0]   = pc_q[1];
      end
      count_d = count_pop;

      case (state_q)
        S_IDLE: begin
          if (count_pop < 2'd2) begin
            state_d    = S_REQ;
            mem_addr_d = fetch_pc_q;
          end
        end
        S_REQ: begin
          if (ack) begin
            // The new entry lands behind whatever survives this edge's pop.
            word_d[count_pop[0]] = mem_read_data;
            pc_d[count_pop[0]]   = fetch_pc_q;
            count_d              = count_pop + 2'd1;
            fetch_pc_d           = fetch_pc_inc;
            if (count_pop == 2'd0) begin
              mem_addr_d = fetch_pc_inc;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          if (ack) begin
            state_d    = S_REQ;
            mem_addr_d = fetch_pc_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign req_d = (state_d != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= 2'd0;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      req_q      <= req_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; count_q alone decides
  // which entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    pc_q   <= pc_d;
  end

  assign mem_read_req = req_q;
  assign mem_addr     = mem_addr_q;
  assign instr_valid  = (count_q != 2'd0);
  assign instr_data   = instr_valid ? word_q[0] : NOP_WORD;
  assign instr_pc     = instr_valid ? pc_q[0] : fetch_pc_q;

endmodule
